// File: rtl/modmul_pm_pkg.sv
// modmul_pm_pkg: shared FSM state type, default sizing and pseudo-Mersenne modulus helper
package modmul_pm_pkg;
  typedef enum logic [1:0] {IDLE, MUL, FOLD, DONE} state_t;
  localparam int WIDTH_DEF = 94;
  localparam int C_DEF = 3;
  localparam int DIGIT_DEF = 2;
  localparam int NDIG = WIDTH_DEF / DIGIT_DEF;
  localparam int TW = WIDTH_DEF + DIGIT_DEF + 2;
  localparam int CNTW = $clog2(NDIG);
  localparam int MAXW = 512;
  function automatic logic [MAXW-1:0] pm_modulus(input int w, input int c);
    return (MAXW'(1) << w) - MAXW'(c);
  endfunction
endpackage

// File: rtl/modmul_pm_fold.sv
// modmul_pm_fold: one pseudo-Mersenne fold, y = x[WIDTH-1:0] + x[IN_W-1:WIDTH]*C
module modmul_pm_fold
  import modmul_pm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int C = C_DEF,
  parameter int IN_W = TW
) (
  input  logic [IN_W-1:0]  x,
  output logic [WIDTH:0]   y
);
  localparam logic [WIDTH:0] CK = (WIDTH+1)'(C);
  assign y = {1'b0, x[WIDTH-1:0]} + (WIDTH+1)'(x[IN_W-1:WIDTH]) * CK;
endmodule

// File: rtl/modmul_pm_serial.sv
// modmul_pm_serial: digit-serial (a*b) mod (2^WIDTH - C); MODMUL_PM_SKIP_LZ_EN skips leading zero digits of b
module modmul_pm_serial
  import modmul_pm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int C = C_DEF,
  parameter int DIGIT = DIGIT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] m,
  output logic             busy
);
  localparam int ndig = WIDTH / DIGIT;
  localparam int tw = WIDTH + DIGIT + 2;
  localparam int cntw = ndig > 1 ? $clog2(ndig) : 1;
  localparam logic [WIDTH:0] PX = (WIDTH+1)'(pm_modulus(WIDTH, C));
  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("WIDTH must be a multiple of DIGIT");
  end
  state_t state, nxt;
  logic [WIDTH-1:0] a_r, b_r;
  logic [WIDTH:0] acc, f1, f2, r, r1, r2;
  logic [cntw-1:0] cnt, top;
  logic [DIGIT-1:0] d;
  logic [tw-1:0] t;
  logic bz, accept;
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  assign out_valid = state == DONE;
  assign accept = in_ready && in_valid;
`ifdef MODMUL_PM_SKIP_LZ_EN
  assign bz = b == '0;
  always_comb begin
    top = '0;
    for (int i = 0; i < ndig; i++) if (DIGIT'(b >> (i*DIGIT)) != '0) top = cntw'(i);
  end
`else
  assign bz = 1'b0;
  assign top = cntw'(ndig - 1);
`endif
  // Horner step: acc*2^DIGIT + a*d, folded twice to keep acc below 2^(WIDTH+1)
  assign d = DIGIT'(b_r >> (int'(cnt) * DIGIT));
  assign t = tw'({acc, {DIGIT{1'b0}}}) + tw'(a_r) * tw'(d);
  modmul_pm_fold #(.WIDTH(WIDTH), .C(C), .IN_W(tw)) u_fold1 (.x(t), .y(f1));
  modmul_pm_fold #(.WIDTH(WIDTH), .C(C), .IN_W(WIDTH+1)) u_fold2 (.x(f1), .y(f2));
  modmul_pm_fold #(.WIDTH(WIDTH), .C(C), .IN_W(WIDTH+1)) u_fold3 (.x(acc), .y(r));
  assign r1 = r >= PX ? r - PX : r;
  assign r2 = r1 >= PX ? r1 - PX : r1;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (in_valid) nxt = bz ? DONE : MUL;
      MUL: if (cnt == '0) nxt = FOLD;
      FOLD: nxt = DONE;
      DONE: if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a_r <= '0;
      b_r <= '0;
      acc <= '0;
      cnt <= '0;
      m <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        a_r <= a;
        b_r <= b;
        acc <= '0;
        cnt <= top;
        if (bz) m <= '0;
      end
      if (state == MUL) begin
        acc <= f2;
        cnt <= cnt - cntw'(1);
      end
      if (state == FOLD) m <= WIDTH'(r2);
    end
  end
endmodule

// File: tb/tb_modmul_pm_serial.sv
// tb_modmul_pm_serial: directed and random checks of modmul_pm_serial against a scoreboard of (a*b) mod P
module tb_modmul_pm_serial;
  localparam int W = 94;
  localparam logic [W-1:0] PP = {W{1'b1}} - W'(2);
`ifdef MODMUL_PM_SKIP_LZ_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset, in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0] a, b, m;
  logic [W-1:0] q[$];
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  modmul_pm_serial dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .m(m), .busy(busy)
  );
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] p;
    p = (2*W)'(x) * (2*W)'(y);
    return W'(p % (2*W)'(PP));
  endfunction
  function automatic int exp_lat(input logic [W-1:0] y);
    int top;
    top = -1;
    for (int i = 0; i < W/2; i++) if (y[2*i +: 2] != 2'b00) top = i;
    return SKIP ? (top < 0 ? 0 : top + 2) : W/2 + 1;
  endfunction
  function automatic logic [W-1:0] rnd();
    return W'({$urandom, $urandom, $urandom});
  endfunction
  task automatic op(input string tag, input logic [W-1:0] ai, input logic [W-1:0] bi,
                    input logic [W-1:0] want, input int hold);
    int lat;
    logic bok;
    logic [W-1:0] e;
    chk({tag, ".in_ready"}, W'(in_ready), W'(1));
    in_valid = 1'b1;
    a = ai;
    b = bi;
    q.push_back(want);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    lat = 0;
    bok = busy;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      bok &= busy;
    end
    chk({tag, ".lat"}, W'(lat), W'(exp_lat(bi)));
    chk({tag, ".busy"}, W'(bok), W'(1));
    e = 'x;
    if (q.size() != 0) e = q.pop_front();
    chk({tag, ".m"}, m, e);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = rnd();
      b = rnd();
      @(posedge clk); #1;
      chk({tag, ".hold_valid"}, W'(out_valid), W'(1));
      chk({tag, ".hold_m"}, m, e);
      chk({tag, ".hold_in_ready"}, W'(in_ready), W'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".idle_in_ready"}, W'(in_ready), W'(1));
    chk({tag, ".idle_valid"}, W'(out_valid), W'(0));
  endtask
  initial begin
    logic [W-1:0] ai, bi;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst.in_ready", W'(in_ready), W'(1));
    chk("rst.out_valid", W'(out_valid), W'(0));
    chk("rst.busy", W'(busy), W'(0));
    chk("rst.m", m, W'(0));
    op("small", W'(2), W'(3), W'(6), 0);
    op("pm1sq", PP - W'(1), PP - W'(1), W'(1), 0);
    op("pow93", W'(1) << 93, W'(2), W'(3), 0);
    op("nonred", PP, W'(5), W'(0), 0);
    op("allone", '1, '1, W'(4), 0);
    op("backpressure", W'(11), W'(13), W'(143), 10);
    op("b_one", W'(12345), W'(1), W'(12345), 0);
    op("b_zero", W'(99), W'(0), W'(0), 0);
    in_valid = 1'b1;
    a = W'(5);
    b = W'(6);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1 chk("midop.busy", W'(busy), W'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst.in_ready", W'(in_ready), W'(1));
    chk("midrst.out_valid", W'(out_valid), W'(0));
    chk("midrst.m", m, W'(0));
    op("after_rst", W'(7), W'(9), W'(63), 0);
    for (int n = 0; n < 300; n++) begin
      ai = rnd();
      bi = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : rnd();
      op("rnd", ai, bi, ref_mul(ai, bi), int'($urandom_range(0, 3)));
    end
    chk("sb_empty", W'(q.size()), W'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/modmul_pm_serial.md
Name: modmul_pm_serial

Overview:
Parametrised, digit-serial modular multiplier for pseudo-Mersenne moduli P = 2^WIDTH - C. It sits in the datapath as a multi-cycle arithmetic unit. It accepts an operand pair over a valid/ready handshake, processes DIGIT bits of b per cycle (MSB-first Horner with interleaved folding), and returns the fully reduced product (a*b) mod P over a second valid/ready handshake. It replaces the single-cycle, fixed-width full-product multiplier where area matters more than latency.

Parameters:
WIDTH, 94, operand/result width; P = 2^WIDTH - C
C, 3, modulus offset; 1 <= C < 2^(WIDTH-DIGIT-3)
DIGIT, 2, bits of b consumed per MUL cycle; WIDTH % DIGIT == 0 (elaboration error otherwise)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands
a  in  WIDTH  operand, any value < 2^WIDTH
b  in  WIDTH  operand, any value < 2^WIDTH
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
m  out  WIDTH  (a*b) mod P, always in [0, P-1]
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, m=0, busy=0, internal acc/counter=0. Reset mid-operation aborts the operation; the result is discarded and is never presented.
- States: IDLE, MUL, FOLD, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: register a_r=a, b_r=b, acc=0, cnt=WIDTH/DIGIT-1, go to MUL.
- MUL, one digit per cycle, MSB first:
  - d = b_r[cnt*DIGIT +: DIGIT].
  - t = acc*2^DIGIT + a_r*d.
  - acc <= fold(fold(t)), where fold(x) = x[WIDTH-1:0] + x[top:WIDTH]*C.
  - Invariant: acc < 2^(WIDTH+1).
  - When cnt==0, go to FOLD; otherwise decrement cnt.
- FOLD:
  - r = fold(acc).
  - Subtract P while r >= P (at most twice; r < 3P).
  - m <= r, out_valid <= 1, go to DONE.
- DONE:
  - out_valid=1; m is held stable.
  - On out_ready, go to IDLE and drop out_valid the next cycle.
  - in_ready=0 in DONE; there is no same-cycle turnaround.
- Latency:
  - The first out_valid cycle is WIDTH/DIGIT+1 cycles after the accept edge (48 at defaults).
  - Minimum initiation interval is WIDTH/DIGIT+3 cycles.
- Arithmetic:
  - Internal t width is WIDTH+DIGIT+2 bits; all intermediates are unsigned.
  - Non-reduced inputs (a or b >= P) still yield the fully reduced result.
- in_valid is ignored outside IDLE; a and b need only be stable in the accept cycle.
- out_valid must not drop and m must not change while out_ready is low.

Optional Feature:
MODMUL_PM_SKIP_LZ_EN.
- Defined:
  - On accept, cnt is loaded with the index of the most significant nonzero digit of b (leading zero digits leave acc=0, so skipping them is exact).
  - If b==0, go directly to DONE with m=0 and out_valid=1 on the cycle after accept.
  - Latency becomes (index+1)+1 cycles.
- Undefined: fixed latency as above.
- The result value is identical in both builds.

Decomposition:
- Package modmul_pm_pkg:
  - state enum {IDLE, MUL, FOLD, DONE}.
  - Width-derived localparams: NDIG=WIDTH/DIGIT, TW=WIDTH+DIGIT+2, CNTW=$clog2(NDIG).
  - Function returning P for given WIDTH, C.
- One combinational sub-module, modmul_pm_fold (parameters WIDTH, C, IN_W), implementing fold(). It is instantiated three times: two in MUL, one in FOLD.

Test Plan:
- WIDTH=94, C=3, a=2, b=3 -> m=6. out_valid first high exactly 48 cycles after the accept edge; busy high throughout.
- a=P-1, b=P-1 -> m=1. a=2^93, b=2 -> m=3. a=P, b=5 (non-reduced) -> m=0. a=2^94-1, b=2^94-1 -> m=4.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> m and out_valid stable, in_ready=0, new in_valid ignored. After out_ready, the next accept is possible 2 cycles later.
- Reset: assert reset 20 cycles into MUL -> next cycle in_ready=1, out_valid=0, m=0. The following operation a=7, b=9 -> m=63 with nominal latency.
- Random: 10k random a,b, plus configs (WIDTH=32, C=5, DIGIT=4) and (WIDTH=255, C=19, DIGIT=1), compared against a reference model (a*b)%P with random out_ready.
- With MODMUL_PM_SKIP_LZ_EN:
  - b=0 -> m=0 one cycle after accept.
  - b=1, a=12345 -> m=12345, out_valid 2 cycles after accept.
  - Without the macro, b=1 still takes 48 cycles.
